tft_ctrl: RTL and testbench
===========================

Name: tft_ctrl

Overview:
- Timing controller for the 480x272 TFT panel, running on the 9 MHz pixel clock.
- Generates HSYNC, VSYNC and DE, and drives pixel coordinates to the pixel generator.
- Takes back the 16-bit RGB565 pixel data, which the generator registers with one clock of latency.
- Forwards that data to the panel pins and drives the backlight enable.

Parameters:
- H_SYNC, 10'd41: hsync pulse width in clocks
- H_BACK, 10'd2: horizontal back porch
- H_VALID, 10'd480: active pixels per line
- H_FRONT, 10'd2: horizontal front porch
- H_TOTAL, 10'd525: clocks per line (sum of the four H values above)
- V_SYNC, 10'd10: vsync pulse width in lines
- V_BACK, 10'd2: vertical back porch
- V_VALID, 10'd272: active lines
- V_FRONT, 10'd2: vertical front porch
- V_TOTAL, 10'd286: lines per frame

Ports:
- tft_clk_9m, input, 1: pixel clock, 9 MHz
- sys_rst_n, input, 1: asynchronous reset, active low
- pix_data, input, 16: RGB565 from the pixel generator; the value for the coordinate presented at cycle n arrives at cycle n+1
- pix_x, output, 10: requested pixel X, 0..479; 10'h3FF when no request
- pix_y, output, 10: requested pixel Y, 0..271; 10'h3FF when no request
- rgb_tft, output, 16: panel RGB data
- hsync, output, 1: horizontal sync, active high
- vsync, output, 1: vertical sync, active high
- tft_clk, output, 1: panel clock, equal to tft_clk_9m
- tft_de, output, 1: panel data enable
- tft_bl, output, 1: backlight enable, equal to sys_rst_n
- frame_start, output, 1: one-clock pulse at the start of each frame

Behaviour:
- Clock and reset:
  - Single clock domain, tft_clk_9m.
  - Reset is asynchronous and active low on sys_rst_n.
  - All registers clear on reset.
- cnt_h (10 bit):
  - Reset value 0.
  - Increments every clock; wraps to 0 on the clock after H_TOTAL-1.
- cnt_v (10 bit):
  - Reset value 0.
  - Increments only on the clock where cnt_h == H_TOTAL-1.
  - Wraps to 0 when cnt_h == H_TOTAL-1 and cnt_v == V_TOTAL-1; this is the simultaneous-wrap case, and both counters return to 0 on the same edge.
- Sync outputs:
  - hsync = (cnt_h <= H_SYNC-1).
  - vsync = (cnt_v <= V_SYNC-1).
  - Both are combinational from the counters, so both read 1 while in reset.
- Active window, rgb_valid:
  - cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1], i.e. 43..522.
  - cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID-1], i.e. 12..283.
- Pixel request, pix_req (internal):
  - Same vertical window as rgb_valid.
  - Horizontal window shifted one clock earlier: cnt_h 42..521.
  - The one-clock lead compensates the generator's registered output.
- Coordinates:
  - When pix_req: pix_x = cnt_h - (H_SYNC+H_BACK-1) and pix_y = cnt_v - (V_SYNC+V_BACK).
  - Otherwise both are 10'h3FF.
  - Subtraction is 10-bit unsigned and is only evaluated inside the window, so it never underflows.
- Panel data and enable:
  - rgb_tft = rgb_valid ? pix_data : 16'h0000.
  - tft_de = rgb_valid.
- Output values in reset:
  - tft_de = 0, rgb_tft = 0.
  - pix_x = pix_y = 10'h3FF.
  - frame_start = 0.
  - tft_bl = 0, since it follows sys_rst_n.
- frame_start:
  - Registered. Asserted for exactly one clock, on the clock after cnt_h == H_TOTAL-1 and cnt_v == V_TOTAL-1, i.e. aligned with cnt_h = cnt_v = 0.
  - Not asserted on the first frame after reset release.
- Timing totals:
  - Frame period 525 × 286 = 150150 clocks.
  - 480 DE clocks per active line, 272 active lines per frame.
- Reset mid-frame:
  - Counters return to 0 immediately and asynchronously; outputs take their reset values.
  - After release the timing restarts from line 0, pixel 0, with no partial-line artefact beyond the truncated frame.
- pix_data outside the rgb_valid window is ignored.

Test Plan:
- Release reset, count clocks.
  - hsync = 1 for cnt_h 0..40 and 0 from 41.
  - vsync high for the first 10 × 525 = 5250 clocks.
  - Line period 525 clocks; frame_start period 150150 clocks.
- Line 12 (cnt_v = 12).
  - At cnt_h = 42: pix_x = 0, pix_y = 0, tft_de = 0.
  - At cnt_h = 43: tft_de = 1.
  - At cnt_h = 521: pix_x = 479.
  - At cnt_h = 522: last tft_de = 1.
  - At cnt_h = 523: tft_de = 0, pix_x = 3FF.
- Model the generator as pix_data <= {pix_x[5:0], pix_y[9:0]} registered.
  - rgb_tft at every DE clock equals the coordinates requested one clock earlier.
  - DE count is 480 × 272 = 130560 per frame.
- Drive pix_data = 16'hFEC0 constantly.
  - rgb_tft = 0 whenever tft_de = 0, including porches and lines 0..11 and 284..285.
- Corner coordinates.
  - Last request at cnt_v = 283: pix_y = 271.
  - At cnt_v = 284: pix_y = 3FF.
  - Wrap from cnt_h = 524, cnt_v = 285 to 0,0, with frame_start = 1 for one clock.
- Assert sys_rst_n = 0 mid-line at cnt_h = 300, cnt_v = 100.
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - On release, the next clock has cnt_h = 1 and the first DE appears after 12 × 525 + 43 clocks.

Source files
------------

// File: rtl/tft_ctrl.sv
// rtl/tft_ctrl.sv - 480x272 TFT timing controller: sync, data enable, pixel request and data forwarding
module tft_ctrl #(
    parameter logic [9:0] H_SYNC  = 10'd41,
    parameter logic [9:0] H_BACK  = 10'd2,
    parameter logic [9:0] H_VALID = 10'd480,
    parameter logic [9:0] H_FRONT = 10'd2,
    parameter logic [9:0] H_TOTAL = 10'd525,
    parameter logic [9:0] V_SYNC  = 10'd10,
    parameter logic [9:0] V_BACK  = 10'd2,
    parameter logic [9:0] V_VALID = 10'd272,
    parameter logic [9:0] V_FRONT = 10'd2,
    parameter logic [9:0] V_TOTAL = 10'd286
) (
    input  logic        tft_clk_9m,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] rgb_tft,
    output logic        hsync,
    output logic        vsync,
    output logic        tft_clk,
    output logic        tft_de,
    output logic        tft_bl,
    output logic        frame_start
);

    // Active window bounds; the request window leads the data window by one
    // clock because the pixel generator registers its output.
    localparam logic [9:0] H_ACT_S = H_SYNC + H_BACK;
    localparam logic [9:0] H_ACT_E = H_SYNC + H_BACK + H_VALID - 10'd1;
    localparam logic [9:0] H_REQ_S = H_ACT_S - 10'd1;
    localparam logic [9:0] H_REQ_E = H_ACT_E - 10'd1;
    localparam logic [9:0] V_ACT_S = V_SYNC + V_BACK;
    localparam logic [9:0] V_ACT_E = V_SYNC + V_BACK + V_VALID - 10'd1;

    logic [9:0] cnt_h_q, cnt_h_d;
    logic [9:0] cnt_v_q, cnt_v_d;
    logic       frame_start_q, frame_start_d;
    logic       line_end;
    logic       frame_end;
    logic       rgb_valid;
    logic       pix_req;
    logic       v_win;

    // Next-state for the raster counters and the frame-start pulse
    always_comb begin
        line_end      = (cnt_h_q == H_TOTAL - 10'd1);
        frame_end     = line_end && (cnt_v_q == V_TOTAL - 10'd1);
        cnt_h_d       = line_end ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d       = cnt_v_q;
        if (line_end) begin
            cnt_v_d = frame_end ? 10'd0 : cnt_v_q + 10'd1;
        end
        frame_start_d = frame_end;
    end

    // Raster state registers, cleared asynchronously
    always_ff @(posedge tft_clk_9m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q       <= 10'd0;
            cnt_v_q       <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Panel-side outputs decoded straight from the counters
    always_comb begin
        v_win       = (cnt_v_q >= V_ACT_S) && (cnt_v_q <= V_ACT_E);
        rgb_valid   = v_win && (cnt_h_q >= H_ACT_S) && (cnt_h_q <= H_ACT_E);
        pix_req     = v_win && (cnt_h_q >= H_REQ_S) && (cnt_h_q <= H_REQ_E);
        hsync       = (cnt_h_q <= H_SYNC - 10'd1);
        vsync       = (cnt_v_q <= V_SYNC - 10'd1);
        pix_x       = pix_req ? (cnt_h_q - H_REQ_S) : 10'h3FF;
        pix_y       = pix_req ? (cnt_v_q - V_ACT_S) : 10'h3FF;
        rgb_tft     = rgb_valid ? pix_data : 16'h0000;
        tft_de      = rgb_valid;
        tft_clk     = tft_clk_9m;
        tft_bl      = sys_rst_n;
        frame_start = frame_start_q;
    end

endmodule

// File: tb/tb_tft_ctrl.sv
// tb/tb_tft_ctrl.sv - directed self-checking bench for tft_ctrl
`timescale 1ns/1ps
module tb_tft_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] pix_data;
    logic [9:0]  pix_x, pix_y;
    logic [15:0] rgb_tft;
    logic        hsync, vsync, tft_clk, tft_de, tft_bl, frame_start;

    logic [15:0] pix_data_s;
    logic [9:0]  pix_x_s, pix_y_s;
    logic [15:0] rgb_tft_s;
    logic        hsync_s, vsync_s, tft_clk_s, tft_de_s, tft_bl_s, frame_start_s;

    logic        gen_mode;
    int          n_checks;
    int          n_fail;
    int          cyc;

    tft_ctrl dut (
        .tft_clk_9m  (clk),
        .sys_rst_n   (rst_n),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .rgb_tft     (rgb_tft),
        .hsync       (hsync),
        .vsync       (vsync),
        .tft_clk     (tft_clk),
        .tft_de      (tft_de),
        .tft_bl      (tft_bl),
        .frame_start (frame_start)
    );

    // Shrunken raster (11 x 7 clocks) so frame wrap and frame_start fit in a short run
    tft_ctrl #(
        .H_SYNC(10'd3), .H_BACK(10'd2), .H_VALID(10'd4), .H_FRONT(10'd2), .H_TOTAL(10'd11),
        .V_SYNC(10'd2), .V_BACK(10'd1), .V_VALID(10'd3), .V_FRONT(10'd1), .V_TOTAL(10'd7)
    ) dut_s (
        .tft_clk_9m  (clk),
        .sys_rst_n   (rst_n),
        .pix_data    (pix_data_s),
        .pix_x       (pix_x_s),
        .pix_y       (pix_y_s),
        .rgb_tft     (rgb_tft_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .tft_clk     (tft_clk_s),
        .tft_de      (tft_de_s),
        .tft_bl      (tft_bl_s),
        .frame_start (frame_start_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel generator model: registered coordinates, or a constant colour
    always @(posedge clk) begin
        pix_data <= gen_mode ? {pix_x[5:0], pix_y} : 16'hFEC0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        int h, v, de_cnt;
        logic [9:0] px_prev, py_prev;
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        gen_mode   = 1'b0;
        pix_data   = 16'hFEC0;
        pix_data_s = 16'hFEC0;
        rst_n      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_de", tft_de, 0);
        check("rst_rgb", rgb_tft, 0);
        check("rst_pix_x", pix_x, 10'h3FF);
        check("rst_pix_y", pix_y, 10'h3FF);
        check("rst_frame_start", frame_start, 0);
        check("rst_bl", tft_bl, 0);
        check("tft_clk_hi", tft_clk, 1);

        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        #1;
        check("tft_clk_lo", tft_clk, 0);
        check("bl_on", tft_bl, 1);
        check("hsync_c0", hsync, 1);

        // Cycle-by-cycle: main hsync edge, and full small-raster timing over two frames
        for (int k = 1; k <= 170; k++) begin
            step();
            check("hsync", hsync, ((cyc % 525) <= 40) ? 1 : 0);
            check("vsync", vsync, 1);
            h = cyc % 11;
            v = (cyc / 11) % 7;
            check("s_frame_start", frame_start_s, (h == 0 && v == 0) ? 1 : 0);
            check("s_hsync", hsync_s, (h <= 2) ? 1 : 0);
            check("s_vsync", vsync_s, (v <= 1) ? 1 : 0);
            check("s_de", tft_de_s, (h >= 5 && h <= 8 && v >= 3 && v <= 5) ? 1 : 0);
            check("s_rgb", rgb_tft_s, (h >= 5 && h <= 8 && v >= 3 && v <= 5) ? 16'hFEC0 : 16'h0);
            check("s_pix_x", pix_x_s, (h >= 4 && h <= 7 && v >= 3 && v <= 5) ? h - 4 : 10'h3FF);
            check("s_pix_y", pix_y_s, (h >= 4 && h <= 7 && v >= 3 && v <= 5) ? v - 3 : 10'h3FF);
        end

        goto(524);
        check("hsync_h524", hsync, 0);
        goto(525);
        check("hsync_line2", hsync, 1);
        goto(525 + 41);
        check("hsync_line2_off", hsync, 0);
        goto(5249);
        check("vsync_last", vsync, 1);
        goto(5250);
        check("vsync_off", vsync, 0);

        // Line 11 is vertical back porch: constant colour must not reach the panel
        goto(11 * 525 + 100);
        check("l11_de", tft_de, 0);
        check("l11_rgb", rgb_tft, 0);
        check("l11_pix_y", pix_y, 10'h3FF);
        goto(11 * 525 + 524);
        gen_mode = 1'b1;

        // First active line: window edges and one-clock data alignment
        goto(12 * 525 + 41);
        check("l12_h41_pix_x", pix_x, 10'h3FF);
        px_prev = pix_x;
        py_prev = pix_y;
        de_cnt  = 0;
        for (int hh = 42; hh <= 524; hh++) begin
            step();
            check("l12_de", tft_de, (hh >= 43 && hh <= 522) ? 1 : 0);
            check("l12_pix_x", pix_x, (hh >= 42 && hh <= 521) ? hh - 42 : 10'h3FF);
            check("l12_pix_y", pix_y, (hh >= 42 && hh <= 521) ? 0 : 10'h3FF);
            if (hh >= 43 && hh <= 522) begin
                check("l12_rgb", rgb_tft, {px_prev[5:0], py_prev});
                de_cnt++;
            end else begin
                check("l12_rgb_idle", rgb_tft, 0);
            end
            px_prev = pix_x;
            py_prev = pix_y;
        end
        check("l12_de_count", de_cnt, 480);

        goto(13 * 525 + 100);
        check("l13_rgb", rgb_tft, 16'hE401);
        check("l13_pix_x", pix_x, 58);
        check("l13_pix_y", pix_y, 1);
        goto(13 * 525 + 524);
        gen_mode = 1'b0;

        goto(14 * 525 + 20);
        check("l14_porch_rgb", rgb_tft, 0);
        goto(14 * 525 + 100);
        check("l14_de", tft_de, 1);
        check("l14_rgb", rgb_tft, 16'hFEC0);

        // Asynchronous reset mid-line inside the active window
        goto(14 * 525 + 300);
        check("pre_rst_de", tft_de, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_de", tft_de, 0);
        check("arst_rgb", rgb_tft, 0);
        check("arst_pix_x", pix_x, 10'h3FF);
        check("arst_pix_y", pix_y, 10'h3FF);
        check("arst_hsync", hsync, 1);
        check("arst_vsync", vsync, 1);
        check("arst_bl", tft_bl, 0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_de", tft_de, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        goto(40);
        check("rel_hsync_h40", hsync, 1);
        goto(41);
        check("rel_hsync_h41", hsync, 0);
        goto(43);
        check("rel_l0_de", tft_de, 0);
        goto(6342);
        check("rel_de_h42", tft_de, 0);
        check("rel_pix_x_h42", pix_x, 0);
        goto(6343);
        check("rel_first_de", tft_de, 1);
        check("rel_frame_start", frame_start, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
